// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed byte stream into imem line and dmem word writes.
// Optional trailing XOR checksum byte when PROG_LOADER_CHKSUM_EN is defined.

`ifndef INSN_LEN
`define INSN_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

// state  | meaning
// S_HI0  | waiting for imem line count, low byte
// S_HI1  | waiting for imem line count, high byte
// S_IMEM | receiving imem payload, 16 bytes per line
// S_DH0  | waiting for dmem word count, low byte
// S_DH1  | waiting for dmem word count, high byte
// S_DMEM | receiving dmem payload, 4 bytes per word
// S_CHK  | waiting for checksum byte (checksum build only)
// S_DONE | image loaded, pipeline released
// S_ERR  | malformed image, held until reset
module prog_loader #(
  parameter int IMEM_LINES = 512,
  parameter int DMEM_WORDS = 4096
) (
  input  logic                      clk,
  input  logic                      reset_x,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic                      prog_loading,
  output logic [4*`INSN_LEN-1:0]    prog_loaddata,
  output logic [`ADDR_LEN-1:0]      prog_loadaddr,
  output logic                      prog_imem_we,
  output logic                      prog_dmem_we,
  output logic                      loaded,
  output logic                      load_err
);

  localparam logic [15:0] IMEM_MAX = 16'(IMEM_LINES);
  localparam logic [15:0] DMEM_MAX = 16'(DMEM_WORDS);

  typedef enum logic [3:0] {
    S_HI0, S_HI1, S_IMEM, S_DH0, S_DH1, S_DMEM,
`ifdef PROG_LOADER_CHKSUM_EN
    S_CHK,
`endif
    S_DONE, S_ERR
  } state_t;

  state_t       state;
  logic [7:0]   cnt_lo;
  logic [15:0]  n_items;
  logic [15:0]  item_cnt;
  logic [3:0]   byte_cnt;
  logic [127:0] asm_q;
`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0]   chk_q;
`else
  logic         dmem_fin;
`endif

  logic         acc;
  logic [15:0]  cnt_hdr;
  logic [15:0]  item_nxt;
  logic [127:0] asm_nxt;

  assign acc      = rx_valid && rx_ready;
  assign cnt_hdr  = {rx_data, cnt_lo};
  assign item_nxt = item_cnt + 16'd1;
  // Shifting in from the top leaves byte 0 lowest; a 4-byte dmem word lands in [127:96].
  assign asm_nxt  = {rx_data, asm_q[127:8]};

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state         <= S_HI0;
      cnt_lo        <= '0;
      n_items       <= '0;
      item_cnt      <= '0;
      byte_cnt      <= '0;
      asm_q         <= '0;
      rx_ready      <= 1'b1;
      prog_loading  <= 1'b1;
      prog_loaddata <= '0;
      prog_loadaddr <= '0;
      prog_imem_we  <= 1'b0;
      prog_dmem_we  <= 1'b0;
      loaded        <= 1'b0;
      load_err      <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_q         <= '0;
`else
      dmem_fin      <= 1'b0;
`endif
    end else begin
      prog_imem_we <= 1'b0;
      prog_dmem_we <= 1'b0;
      case (state)
        S_HI0, S_DH0: if (acc) begin
          cnt_lo <= rx_data;
          state  <= (state == S_HI0) ? S_HI1 : S_DH1;
        end
        S_HI1: if (acc) begin
          n_items  <= cnt_hdr;
          item_cnt <= '0;
          byte_cnt <= '0;
          if (cnt_hdr > IMEM_MAX) begin
            state    <= S_ERR;
            load_err <= 1'b1;
            rx_ready <= 1'b0;
          end else if (cnt_hdr == 16'd0) begin
            state <= S_DH0;
          end else begin
            state <= S_IMEM;
          end
        end
        S_DH1: if (acc) begin
          n_items  <= cnt_hdr;
          item_cnt <= '0;
          byte_cnt <= '0;
          if (cnt_hdr > DMEM_MAX) begin
            state    <= S_ERR;
            load_err <= 1'b1;
            rx_ready <= 1'b0;
          end else if (cnt_hdr == 16'd0) begin
`ifdef PROG_LOADER_CHKSUM_EN
            state <= S_CHK;
`else
            state        <= S_DONE;
            loaded       <= 1'b1;
            prog_loading <= 1'b0;
            rx_ready     <= 1'b0;
`endif
          end else begin
            state <= S_DMEM;
          end
        end
        S_IMEM: if (acc) begin
`ifdef PROG_LOADER_CHKSUM_EN
          chk_q <= chk_q ^ rx_data;
`endif
          if (byte_cnt == 4'd15) begin
            prog_imem_we  <= 1'b1;
            prog_loaddata <= asm_nxt;
            prog_loadaddr <= {12'd0, item_cnt, 4'd0};
            asm_q         <= '0;
            byte_cnt      <= '0;
            item_cnt      <= item_nxt;
            if (item_nxt == n_items) state <= S_DH0;
          end else begin
            asm_q    <= asm_nxt;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        S_DMEM: begin
`ifndef PROG_LOADER_CHKSUM_EN
          // Completion waits one cycle so loaded follows the final strobe.
          if (dmem_fin) begin
            state        <= S_DONE;
            loaded       <= 1'b1;
            prog_loading <= 1'b0;
            rx_ready     <= 1'b0;
          end else
`endif
          if (acc) begin
`ifdef PROG_LOADER_CHKSUM_EN
            chk_q <= chk_q ^ rx_data;
`endif
            if (byte_cnt == 4'd3) begin
              prog_dmem_we  <= 1'b1;
              prog_loaddata <= asm_nxt;
              prog_loadaddr <= {14'd0, item_cnt, 2'd0};
              asm_q         <= '0;
              byte_cnt      <= '0;
              item_cnt      <= item_nxt;
              if (item_nxt == n_items) begin
`ifdef PROG_LOADER_CHKSUM_EN
                state <= S_CHK;
`else
                dmem_fin <= 1'b1;
`endif
              end
            end else begin
              asm_q    <= asm_nxt;
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
`ifdef PROG_LOADER_CHKSUM_EN
        S_CHK: if (acc) begin
          rx_ready <= 1'b0;
          if (rx_data == chk_q) begin
            state        <= S_DONE;
            loaded       <= 1'b1;
            prog_loading <= 1'b0;
          end else begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end
        end
`endif
        S_DONE: state <= S_DONE;
        S_ERR:  state <= S_ERR;
        default: begin
          state    <= S_ERR;
          load_err <= 1'b1;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; checksum cases are built when PROG_LOADER_CHKSUM_EN is defined.
`timescale 1ns/1ps
module tb_prog_loader;

  logic         clk = 1'b0;
  logic         reset_x = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_ready, prog_loading, prog_imem_we, prog_dmem_we, loaded, load_err;
  logic [127:0] prog_loaddata;
  logic [31:0]  prog_loadaddr;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0]  imem_addr_q[$];
  logic [127:0] imem_data_q[$];
  int           dmem_strobes = 0;
  logic         both_hi = 1'b0;

  prog_loader dut (
    .clk(clk), .reset_x(reset_x), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .prog_loading(prog_loading), .prog_loaddata(prog_loaddata),
    .prog_loadaddr(prog_loadaddr), .prog_imem_we(prog_imem_we), .prog_dmem_we(prog_dmem_we),
    .loaded(loaded), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prog_imem_we) begin
      imem_addr_q.push_back(prog_loadaddr);
      imem_data_q.push_back(prog_loaddata);
    end
    if (prog_dmem_we) dmem_strobes++;
    if (prog_imem_we && prog_dmem_we) both_hi = 1'b1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset_x  = 1'b0;
    @(posedge clk);
    #1;
    reset_x = 1'b1;
    imem_addr_q.delete();
    imem_data_q.delete();
    dmem_strobes = 0;
    both_hi = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".prog_loading"}, prog_loading, 1'b1);
    check({tag, ".rx_ready"}, rx_ready, 1'b1);
    check({tag, ".loaded"}, loaded, 1'b0);
    check({tag, ".load_err"}, load_err, 1'b0);
    check({tag, ".we"}, {prog_imem_we, prog_dmem_we}, 2'b00);
    check({tag, ".loaddata"}, prog_loaddata, 128'h0);
    check({tag, ".loadaddr"}, prog_loadaddr, 32'h0);
  endtask

  // Single-line / single-word image; checks strobes and completion.
  task automatic basic_image(input string tag);
    send(8'h01); send(8'h00);
    for (int b = 0; b < 16; b++) send(8'(b));
    send(8'h01); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    check({tag, ".dmem_we"}, prog_dmem_we, 1'b1);
    check({tag, ".dmem_addr"}, prog_loadaddr, 32'h0);
    check({tag, ".dmem_data"}, prog_loaddata, 128'h11223344_00000000_00000000_00000000);
`ifdef PROG_LOADER_CHKSUM_EN
    send(8'h44);
    rx_valid = 1'b0;
`else
    check({tag, ".loaded_early"}, loaded, 1'b0);
    rx_valid = 1'b0;
    @(posedge clk); #1;
`endif
    check({tag, ".loaded"}, loaded, 1'b1);
    check({tag, ".prog_loading"}, prog_loading, 1'b0);
    check({tag, ".rx_ready"}, rx_ready, 1'b0);
    check({tag, ".imem_n"}, 32'(imem_addr_q.size()), 32'd1);
    if (imem_addr_q.size() > 0) begin
      check({tag, ".imem_addr"}, imem_addr_q[0], 32'h0);
      check({tag, ".imem_data"}, imem_data_q[0], 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    end
    check({tag, ".dmem_n"}, 32'(dmem_strobes), 32'd1);
    check({tag, ".both_hi"}, both_hi, 1'b0);
  endtask

  logic [127:0] exp_line [3];

  initial begin
    exp_line[0] = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    exp_line[1] = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    exp_line[2] = 128'h2F2E2D2C_2B2A2928_27262524_23222120;

    // Reset state
    do_reset();
    check_reset_vals("reset");

    basic_image("basic");

    // Three lines streamed back-to-back, no dmem
    do_reset();
    send(8'h03); send(8'h00);
    for (int b = 0; b < 48; b++) send(8'(b));
    send(8'h00); send(8'h00);
`ifdef PROG_LOADER_CHKSUM_EN
    send(8'h00);
`endif
    rx_valid = 1'b0;
    check("burst.loaded", loaded, 1'b1);
    check("burst.imem_n", 32'(imem_addr_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < imem_addr_q.size(); i++) begin
      check("burst.addr", imem_addr_q[i], 32'(i * 16));
      check("burst.data", imem_data_q[i], exp_line[i]);
    end
    check("burst.dmem_n", 32'(dmem_strobes), 32'd0);

    // Empty image
    do_reset();
    send(8'h00); send(8'h00); send(8'h00);
    check("empty.not_yet", loaded, 1'b0);
    send(8'h00);
`ifdef PROG_LOADER_CHKSUM_EN
    send(8'h00);
`endif
    rx_valid = 1'b0;
    check("empty.loaded", loaded, 1'b1);
    check("empty.prog_loading", prog_loading, 1'b0);
    check("empty.strobes", 32'(imem_addr_q.size() + dmem_strobes), 32'd0);

    // Oversized imem count 513
    do_reset();
    send(8'h01); send(8'h02);
    rx_valid = 1'b0;
    check("ovf.load_err", load_err, 1'b1);
    check("ovf.rx_ready", rx_ready, 1'b0);
    check("ovf.prog_loading", prog_loading, 1'b1);
    for (int b = 0; b < 20; b++) send(8'(b));
    rx_valid = 1'b0;
    check("ovf.strobes", 32'(imem_addr_q.size() + dmem_strobes), 32'd0);
    check("ovf.loaded", loaded, 1'b0);

    // Reset in the middle of line 2, then a fresh full image
    do_reset();
    send(8'h03); send(8'h00);
    for (int b = 0; b < 21; b++) send(8'(b));
    check("mid.line1_seen", 32'(imem_addr_q.size()), 32'd1);
    rx_valid = 1'b0;
    reset_x = 1'b0;
    @(posedge clk); #1;
    reset_x = 1'b1;
    check_reset_vals("mid");
    imem_addr_q.delete();
    imem_data_q.delete();
    dmem_strobes = 0;
    basic_image("reload");

`ifdef PROG_LOADER_CHKSUM_EN
    // Wrong checksum (0x44 ^ 0x01)
    do_reset();
    send(8'h01); send(8'h00);
    for (int b = 0; b < 16; b++) send(8'(b));
    send(8'h01); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    send(8'h45);
    rx_valid = 1'b0;
    check("badchk.load_err", load_err, 1'b1);
    check("badchk.loaded", loaded, 1'b0);
    check("badchk.prog_loading", prog_loading, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time controller that fills instruction and data memory from a byte stream, typically a UART receiver.
- Drives the program-load side of the top-level memory muxes: prog_loading, prog_loaddata, prog_loadaddr, prog_imem_we, prog_dmem_we.
- Holds prog_loading high until the whole image is written, then releases the pipeline out of reset.
- Parses a length-prefixed image: imem section, then dmem section, then (optionally) a checksum.

Parameters:
- IMEM_LINES, 512, maximum number of 128-bit imem lines (one line = 4 instructions).
- DMEM_WORDS, 4096, maximum number of 32-bit dmem words.

Ports:
- clk  in  1  clock.
- reset_x  in  1  synchronous, active-low reset.
- rx_valid  in  1  input byte valid.
- rx_data  in  8  input byte.
- rx_ready  out  1  loader can accept a byte.
- prog_loading  out  1  load in progress; pipeline must be held in reset while high.
- prog_loaddata  out  4*`INSN_LEN (128)  write data.
- prog_loadaddr  out  `ADDR_LEN (32)  byte address of the write.
- prog_imem_we  out  1  imem line write strobe.
- prog_dmem_we  out  1  dmem word write strobe.
- loaded  out  1  image fully loaded.
- load_err  out  1  malformed image.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_x. The reset values below apply on any clk edge where reset_x=0, including in mid-load; a new load then starts from S_HI0.
- Reset values: prog_loading=1, rx_ready=1, all other outputs 0. State is S_HI0 and all counters and the assembly register are cleared.
- Byte handshake: a byte is accepted on a clk edge where rx_valid && rx_ready. rx_ready=1 in every state except S_DONE and S_ERR, where it is 0. Back-to-back bytes are accepted every cycle, including in a cycle where a write strobe is high.
- Image format:
  - imem line count N_I: 16-bit, little-endian, 2 bytes.
  - N_I*16 imem payload bytes.
  - dmem word count N_D: 16-bit, little-endian, 2 bytes.
  - N_D*4 dmem payload bytes.
  - One checksum byte, only when the checksum option is compiled in.
- States and transitions:
  - S_HI0 → S_HI1: first imem count byte accepted.
  - S_HI1 → S_IMEM: second imem count byte accepted.
  - S_IMEM → S_DH0: all imem lines received.
  - S_DH0 → S_DH1: first dmem count byte accepted.
  - S_DH1 → S_DMEM: second dmem count byte accepted.
  - S_DMEM → S_CHK (if compiled in) or S_DONE: all dmem words received.
  - S_CHK → S_DONE or S_ERR.
  - Count of 0: S_IMEM or S_DMEM is skipped; go straight to the next header/terminal state.
  - Count > IMEM_LINES or > DMEM_WORDS: go to S_ERR on the cycle after the second count byte is accepted.
- Assembly:
  - Within each 32-bit word, bytes arrive LSB first.
  - imem: word k (k=0..3) of a line is placed at bits [32k+31:32k].
  - dmem: the assembled word is driven on prog_loaddata[127:96]; bits [95:0] are 0.
- Write strobe:
  - Asserted for exactly one cycle, on the cycle after the last byte of a line or word is accepted.
  - prog_loaddata and prog_loadaddr are registered together with the strobe and hold their value until the next strobe.
  - imem line i: prog_loadaddr = i<<4.
  - dmem word j: prog_loadaddr = j<<2.
  - prog_imem_we and prog_dmem_we are never high in the same cycle.
- Completion:
  - S_DONE is entered on the cycle after the last write strobe, or after the checksum byte when that option is on.
  - In S_DONE: loaded=1, prog_loading=0, rx_ready=0. S_DONE is held until reset_x=0.
  - Further rx bytes are ignored.
- Error:
  - In S_ERR: load_err=1, prog_loading stays 1, rx_ready=0, no further strobes. S_ERR is held until reset.
- Widths: line and word counters are 16-bit and compared against the parameters; no wrap is possible because counts are bounded.

Optional Feature:
- Macro: PROG_LOADER_CHKSUM_EN.
- Defined:
  - A running 8-bit XOR of all payload bytes (not the count bytes) is kept.
  - After the dmem section, one checksum byte is consumed in S_CHK.
  - Match → S_DONE. Mismatch → S_ERR.
  - The last write strobe has already been issued before S_CHK.
- Not defined: S_CHK does not exist and S_DMEM (or S_DH1 when N_D=0) goes directly to S_DONE.

Test Plan:
- Reset, then stream 01 00, 16 bytes 00..0F, 01 00, 44 33 22 11 (with checksum byte when the option is on) → prog_imem_we once:
  - prog_loadaddr=0x0, prog_loaddata=0x0F0E0D0C_0B0A0908_07060504_03020100.
  - Then prog_dmem_we once: prog_loadaddr=0x0, prog_loaddata[127:96]=0x11223344, [95:0]=0.
  - Then loaded=1 and prog_loading=0 on the next cycle.
- N_I=3 with bytes sent every cycle (rx_valid held high) → three imem strobes at addresses 0x00, 0x10, 0x20, each exactly one cycle, and no byte dropped.
- Header 00 00 00 00 → no strobes; loaded=1 on the cycle after the last count byte (checksum option off).
- Imem count 0x0201 (513 > 512) → load_err=1, rx_ready=0, prog_loading stays 1, no strobes.
- reset_x=0 for one cycle in the middle of line 2 → all outputs return to reset values. A fresh full image then loads correctly, starting at address 0.
- With PROG_LOADER_CHKSUM_EN: correct XOR byte → loaded=1. Wrong byte (XOR^0x01) → load_err=1, loaded stays 0.
